// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared definitions for the UART TX arbiter slice: byte width,
//            TX sequencer state encoding and the round-robin pick function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  localparam int unsigned C_BYTE_W  = 8;
  localparam int unsigned C_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // First requester strictly after 'last', scanning upward and wrapping
  // modulo n. The scan runs from the far end back toward last+1 so that the
  // nearest candidate is the final one written. Returns 'last' when no bit
  // of 'valid' is set. n must be in 1..C_MAX_REQ.
  function automatic int unsigned rr_next(input logic [C_MAX_REQ-1:0] valid,
                                          input int unsigned          last,
                                          input int unsigned          n);
    int unsigned pick;
    int unsigned idx;
    pick = last;
    for (int unsigned k = C_MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if ((valid & (8'd1 << idx)) != 8'd0) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Small circular-buffer FIFO between the arbiter and the UART
//            sequencer. Pointers carry one extra wrap bit so full and empty
//            are told apart by the pointer difference.
// Ports    : clk, resetq (async, active-low)
//            push/wr_data  - write side
//            pop/rd_data   - read side (rd_data shows the head)
//            flush         - synchronous empty, wins over push/pop
//            full, empty, level (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned        C_AW       = $clog2(DEPTH);
  localparam logic [C_AW:0]      C_FULL_LVL = (C_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW:0]    r_wptr;
  logic [C_AW:0]    r_rptr;
  logic             w_push;
  logic             w_pop;

  assign level = r_wptr - r_rptr;
  assign full  = (level == C_FULL_LVL);
  assign empty = (level == '0);

  // Simultaneous push and pop is legal at both extremes: when full the slot
  // being written is the one being read out; when empty the incoming word
  // bypasses straight to rd_data so the level stays unchanged.
  assign w_push = push & ~flush & (~full  | pop);
  assign w_pop  = pop  & ~flush & (~empty | push);

  assign rd_data = empty ? wr_data : r_mem[r_rptr[C_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[C_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among N_REQ byte producers.
//            Round-robin grant locked for a whole packet, a TX FIFO, and a
//            sequencer that strobes the UART and waits out its busy flag.
// Ports    : clk, resetq (async, active-low)
//            req_valid/req_data/req_last/req_ready - producer handshakes
//            tx_wr/tx_data/tx_busy                 - UART side
//            flush                                 - synchronous abort
//            grant_id/grant_vld                    - current owner
//            fifo_level                            - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetq,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [C_BYTE_W*N_REQ-1:0]     req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          tx_wr,
  output logic [C_BYTE_W-1:0]           tx_data,
  input  logic                          tx_busy,
  input  logic                          flush,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          grant_vld,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned      C_IDW      = $clog2(N_REQ);
  localparam logic [C_IDW-1:0] C_LAST_RST = C_IDW'(N_REQ - 1);

  logic                r_grant_vld;
  logic [C_IDW-1:0]    r_grant_id;
  logic [C_IDW-1:0]    r_last_owner;
  logic [C_IDW-1:0]    w_pick_id;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_acc_last;
  logic                w_pop;
  logic [C_BYTE_W-1:0] w_owner_data;
  logic [C_BYTE_W-1:0] w_head;
  logic                r_tx_wr;
  logic [C_BYTE_W-1:0] r_tx_data;
  seq_state_t          r_state;
  seq_state_t          w_state_nxt;

  // ---------------------------------------------------------------- arbiter
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = r_grant_vld & (r_grant_id == C_IDW'(gi)) &
                           ~w_full & ~flush;
  end

  // req_ready is one-hot on the owner, so the masked OR picks out the
  // owner's handshake without indexing by grant_id.
  assign w_accept     = |(req_valid & req_ready);
  assign w_acc_last   = |(req_valid & req_ready & req_last);
  assign w_owner_data = req_data[int'(r_grant_id)*C_BYTE_W +: C_BYTE_W];
  assign w_pick_id    = C_IDW'(rr_next(8'(req_valid), 32'(r_last_owner), N_REQ));

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_grant_vld  <= 1'b0;
      r_grant_id   <= '0;
      r_last_owner <= C_LAST_RST;
    end else if (flush) begin
      // Abort drops the owner but does not count as a completed turn.
      r_grant_vld <= 1'b0;
    end else if (r_grant_vld) begin
      if (w_acc_last) begin
        r_grant_vld  <= 1'b0;
        r_last_owner <= r_grant_id;
      end
    end else if (|req_valid) begin
      r_grant_vld <= 1'b1;
      r_grant_id  <= w_pick_id;
    end
  end

  // ------------------------------------------------------------------- FIFO
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .resetq  (resetq),
    .push    (w_accept),
    .pop     (w_pop),
    .flush   (flush),
    .wr_data (w_owner_data),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // -------------------------------------------------------------- sequencer
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // GUARD spends one cycle ignoring tx_busy because the UART raises busy a
  // cycle after it sees wr.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty && !tx_busy) begin
            w_pop       = 1'b1;
            w_state_nxt = GUARD;
          end
        end
        GUARD: w_state_nxt = DRAIN;
        DRAIN: begin
          if (!tx_busy) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_wr   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_wr <= w_pop;
      if (w_pop) r_tx_data <= w_head;
    end
  end

  assign tx_wr     = r_tx_wr;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign grant_vld = r_grant_vld;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (2 producers, depth 4).
//            A cycle table covers grant/accept/wire timing; producer queues
//            plus a packet-level round-robin model cover the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           resetq;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_wr;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           flush;
  logic [0:0]     grant_id;
  logic           grant_vld;
  logic [2:0]     fifo_level;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetq     (resetq),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .flush      (flush),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld),
    .fifo_level (fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------ producer/UART model
  logic [7:0] pq_data [N][$];
  bit         pq_last [N][$];
  int         plen    [N][$];
  bit         mid     [N];
  int         start   [N];
  logic [7:0] exp_q[$];
  int         cyc, last_wr_cyc, bubble_pct, busy_max, bcnt, bnext;
  bit         busy_hold, hold_active;

  task automatic add_byte(input int p, input logic [7:0] d, input bit last);
    pq_data[p].push_back(d);
    pq_last[p].push_back(last);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pq_data[i].delete(); pq_last[i].delete(); plen[i].delete();
      mid[i] = 1'b0; start[i] = 0;
    end
    exp_q.delete();
    bcnt = 0; bnext = 0; busy_hold = 1'b0; hold_active = 1'b0;
    last_wr_cyc = -100; bubble_pct = 0; busy_max = 0; cyc = 0;
  endtask

  task automatic do_reset();
    resetq = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; flush = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 resetq = 1'b1;
  endtask

  // One clock: drive at posedge+1, sample at negedge, retire handshakes.
  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] others;
    for (int i = 0; i < N; i++) begin
      if (cyc >= start[i] && pq_data[i].size() > 0 &&
          !(mid[i] && ($urandom_range(99) < bubble_pct))) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = pq_data[i][0];
        req_last[i]        = pq_last[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    if (bnext > 0) begin bcnt = bnext; bnext = 0; end
    tx_busy = (busy_hold && hold_active) || (bcnt > 0);
    if (bcnt > 0) bcnt--;

    @(negedge clk);
    acc = req_valid & req_ready;
    check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    for (int j = 0; j < N; j++) begin
      if (mid[j]) begin
        others = req_ready; others[j] = 1'b0;
        check("packet_lock", 32'(others), 32'd0);
      end
    end
    if (tx_wr) begin
      check("wr_spacing", 32'(cyc - last_wr_cyc >= 3), 32'd1);
      last_wr_cyc = cyc;
      check("tx_wr_expected", 32'(tx_wr), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
      if (busy_hold) hold_active = 1'b1;
      else           bnext = int'($urandom_range(busy_max));
    end

    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(pq_data[i].pop_front());
        mid[i] = !pq_last[i].pop_front();
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin step(); n++; end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_prod_empty"}, 32'(pq_data[0].size() + pq_data[1].size()), 32'd0);
    repeat (5) step();
  endtask

  // Packet-level round robin over producers that hold packets from cycle 0.
  task automatic build_expected();
    int rd [N];
    int pp [N];
    int last;
    bit found;
    for (int i = 0; i < N; i++) begin rd[i] = 0; pp[i] = 0; end
    last = N - 1;
    do begin
      found = 1'b0;
      for (int k = 1; k <= N && !found; k++) begin
        int i;
        i = (last + k) % N;
        if (pp[i] < plen[i].size()) begin
          for (int b = 0; b < plen[i][pp[i]]; b++) exp_q.push_back(pq_data[i][rd[i] + b]);
          rd[i] += plen[i][pp[i]];
          pp[i]++;
          last  = i;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  // -------------------------------------------------------- timing table
  typedef struct {
    logic [1:0]  v;   logic [15:0] d;   logic [1:0] l;
    logic [1:0]  rdy; logic        wr;  logic [7:0] dat;
    logic        gv;  logic        gid; logic [2:0] lvl;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got stall, want completion");
    $fatal(1);
  end

  initial begin
    int n;
    // Single byte 0x41 from req0, then both producers with one byte each.
    tbl[0]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{2'b01, 16'h0041, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{2'b01, 16'h0041, 2'b01, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[4]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b1, 8'h41, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{2'b11, 16'h6130, 2'b11, 2'b00, 1'b0, 8'h41, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{2'b11, 16'h6130, 2'b11, 2'b10, 1'b0, 8'h41, 1'b1, 1'b1, 3'd0};
    tbl[7]  = '{2'b01, 16'h0030, 2'b01, 2'b00, 1'b0, 8'h41, 1'b0, 1'b1, 3'd1};
    tbl[8]  = '{2'b01, 16'h0030, 2'b01, 2'b01, 1'b1, 8'h61, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b0, 8'h61, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b0, 8'h61, 1'b0, 1'b0, 3'd1};
    tbl[11] = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b1, 8'h30, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{2'b00, 16'h0000, 2'b00, 2'b00, 1'b0, 8'h30, 1'b0, 1'b0, 3'd0};

    // Reset values while reset is held.
    resetq = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_vld", 32'(grant_vld), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Cycle table.
    do_reset();
    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].v; req_data = tbl[r].d; req_last = tbl[r].l;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      check($sformatf("tbl%0d_tx_wr", r), 32'(tx_wr), 32'(tbl[r].wr));
      check($sformatf("tbl%0d_tx_data", r), 32'(tx_data), 32'(tbl[r].dat));
      check($sformatf("tbl%0d_grant_vld", r), 32'(grant_vld), 32'(tbl[r].gv));
      check($sformatf("tbl%0d_grant_id", r), 32'(grant_id), 32'(tbl[r].gid));
      check($sformatf("tbl%0d_level", r), 32'(fifo_level), 32'(tbl[r].lvl));
      @(posedge clk); #1;
    end

    // Fairness: continuous single-byte packets alternate starting with req0.
    do_reset();
    busy_max = 2;
    for (int k = 0; k < 6; k++) begin
      add_byte(0, 8'(8'h30 + k), 1'b1);
      add_byte(1, 8'(8'h61 + k), 1'b1);
      exp_q.push_back(8'(8'h30 + k));
      exp_q.push_back(8'(8'h61 + k));
    end
    run_until_done("fairness", 300);

    // Packet lock: req1 owns a 3-byte packet, req0 arrives one cycle later.
    do_reset();
    add_byte(1, 8'hA0, 1'b0); add_byte(1, 8'hA1, 1'b0); add_byte(1, 8'hA2, 1'b1);
    add_byte(0, 8'h55, 1'b1);
    start[0] = 1;
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    run_until_done("lock", 100);

    // FIFO full: busy held from the first wr, req0 offers 6 bytes.
    do_reset();
    busy_hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      add_byte(0, 8'(8'h10 + k), k == 5);
      exp_q.push_back(8'(8'h10 + k));
    end
    repeat (12) step();
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_grant_vld", 32'(grant_vld), 32'd1);
    check("full_pending", 32'(pq_data[0].size()), 32'd1);
    busy_hold = 1'b0; hold_active = 1'b0;
    run_until_done("full", 100);

    // Flush mid-packet with three bytes queued and req1 owning the grant.
    do_reset();
    busy_hold = 1'b1;
    for (int k = 0; k < 5; k++) add_byte(1, 8'(8'hC0 + k), k == 4);
    exp_q.push_back(8'hC0);
    n = 0;
    while (fifo_level != 3'd3 && n < 20) begin step(); n++; end
    check("flush_setup_level", 32'(fifo_level), 32'd3);
    check("flush_setup_gid", 32'(grant_id), 32'd1);
    check("flush_setup_gvld", 32'(grant_vld), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", 32'(fifo_level), 32'd0);
    check("flush_grant_vld", 32'(grant_vld), 32'd0);
    check("flush_uart_sent", 32'(exp_q.size()), 32'd0);
    step();
    check("flush_regrant_vld", 32'(grant_vld), 32'd1);
    check("flush_regrant_id", 32'(grant_id), 32'd1);
    repeat (2) step();
    check("flush_relevel", 32'(fifo_level), 32'd1);
    exp_q.push_back(8'hC4);
    busy_hold = 1'b0; hold_active = 1'b0;
    run_until_done("flush", 60);

    // Reset pulse while the sequencer waits in DRAIN.
    do_reset();
    busy_hold = 1'b1;
    add_byte(0, 8'hE0, 1'b0); add_byte(0, 8'hE1, 1'b1);
    exp_q.push_back(8'hE0);
    repeat (8) step();
    check("rst_mid_setup_level", 32'(fifo_level), 32'd1);
    check("rst_mid_setup_data", 32'(tx_data), 32'hE0);
    resetq = 1'b0;
    #1;
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    check("rst_mid_grant_vld", 32'(grant_vld), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    check("rst_mid_tx_wr", 32'(tx_wr), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_tx_wr", 32'(tx_wr), 32'd0);
    end
    do_reset();
    add_byte(0, 8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    run_until_done("rst_resume", 40);

    // Randomized packets, bubbles and UART busy times against the model.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      bubble_pct = 30;
      busy_max   = 4;
      for (int i = 0; i < N; i++) begin
        int np;
        np = int'($urandom_range(6, 3));
        for (int p = 0; p < np; p++) begin
          int len;
          len = int'($urandom_range(4, 1));
          plen[i].push_back(len);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
        end
      end
      build_expected();
      run_until_done($sformatf("random%0d", round), 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among `N_REQ` byte producers (CPU console, debug monitor, trace logger). Round-robin arbitration with packet locking, so a multi-byte message from one producer is never interleaved with another's. A small TX FIFO sits between the arbiter and the UART. A sequencer drives the UART's `wr` strobe and watches its `busy` flag. It sits between the producers and the UART `tx_data`/`wr`/`busy` pins.

## Interface
Parameters:
- `N_REQ`, 2: number of producers, 2..8.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1: system clock.
- `resetq`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`: producer i has a byte.
- `req_data`  in  `8*N_REQ`: byte of producer i in bits `[8i+7:8i]`.
- `req_last`  in  `N_REQ`: byte of producer i ends its packet.
- `req_ready`  out  `N_REQ`: byte of producer i accepted this cycle when both valid and ready.
- `tx_wr`  out  1: one-cycle write strobe to UART.
- `tx_data`  out  8: byte to UART; valid while `tx_wr` is high.
- `tx_busy`  in  1: UART busy flag.
- `flush`  in  1: synchronous abort (wired to UART `brk`).
- `grant_id`  out  `clog2(N_REQ)`: current owner.
- `grant_vld`  out  1: an owner is held.
- `fifo_level`  out  `clog2(FIFO_DEPTH)+1`: FIFO occupancy, 0..`FIFO_DEPTH`.

## Operation
- **Arbitration.** When `grant_vld`=0 and any `req_valid` is high, the block registers a grant. The winner is the first requester after `last_owner`, scanning upward and wrapping modulo `N_REQ`. `last_owner` resets to `N_REQ-1`, so requester 0 has first priority.
- **Accept rule.** `req_ready[i]` = `grant_vld` & (`grant_id`==i) & !full & !`flush`. Only one bit of `req_ready` is ever high.
- **Lock and release.** The grant is held across cycles where the owner's `req_valid` is low. It is released on the accept of a byte with `req_last`=1. At release, `last_owner` ← `grant_id`.
- **FIFO.** First-in first-out. Push and pop in the same cycle is allowed: the level is unchanged, and this also applies when full or empty. A push when full cannot occur, because ready is low.
- **TX sequencer states.**
  - IDLE: when FIFO is non-empty and `tx_busy`=0, pop the head, drive `tx_wr`=1 and `tx_data`=head (both registered), go to GUARD.
  - GUARD: one cycle, unconditional, covers the UART's registered busy; go to DRAIN.
  - DRAIN: stay while `tx_busy`=1; go to IDLE when `tx_busy`=0.
- **Flush.**
  - Empties the FIFO (level→0).
  - Clears `grant_vld` without updating `last_owner`.
  - Sequencer goes to IDLE. A byte already handed to the UART is not recalled.
  - Flush has priority over a same-cycle push or pop.
- **Reset values.**
  - `req_ready`=0, `tx_wr`=0, `tx_data`=0, `grant_vld`=0, `grant_id`=0, `fifo_level`=0.
  - State IDLE, `last_owner`=`N_REQ-1`.

## Timing
- Grant latency: one cycle from `req_valid` rising (no grant held) to `req_ready` high.
- Accept to wire: a byte accepted into an empty FIFO while the sequencer is in IDLE and `tx_busy`=0 appears on `tx_wr` two cycles later (push cycle, then pop/wr register).
- Byte spacing: minimum 3 cycles between `tx_wr` pulses (wr, GUARD, DRAIN), plus the UART busy time.
- Back-to-back accepts: one byte per cycle from the owner until full.
- Re-arbitration after a `last` accept takes one idle cycle: `grant_vld`=0, then the new grant.
- A single-byte packet, i.e. `req_last`=1 on the first byte, is legal.
- `tx_busy` is ignored in GUARD.
- Reset asserted mid-byte clears everything immediately. No `tx_wr` is issued until after deassertion.

## Structure
- Package `uart_arb_pkg` holds:
  - Sequencer state encoding: IDLE=2'd0, GUARD=2'd1, DRAIN=2'd2.
  - Byte width constant 8.
  - Round-robin next-index function.
- Sub-module `uart_tx_fifo`:
  - Parameters: `DEPTH`, `WIDTH`.
  - Ports: push, pop, flush, data, full, empty, level.
  - Circular buffer with pointers one bit wider than the index.
- Top level: arbiter registers and the sequencer FSM.

## Test plan
- **Single byte.** After reset, req0 sends 0x41 with last=1; `tx_busy` is held low. Expect `tx_wr` high for exactly one cycle with `tx_data`=0x41, 3 cycles after `req_valid` rises; grant then releases.
- **Fairness.** Both producers continuously send single-byte packets, 0x30.. and 0x61... Expect the UART byte order 0x30, 0x61, 0x31, 0x62, …, strictly alternating, starting with req0.
- **Packet lock.** req1 sends 0xA0, 0xA1, 0xA2 with last on 0xA2, while req0 is valid from cycle 1. Expect no `req_ready[0]` until after 0xA2 is accepted, and 0xA0–0xA2 contiguous on the UART.
- **FIFO full.** Hold `tx_busy`=1 from the first `tx_wr`; req0 offers 6 bytes. Expect `fifo_level` to saturate at 4 and `req_ready` low. On releasing busy, all bytes drain in order.
- **Flush mid-packet.** Assert `flush` for one cycle with `fifo_level`=3 and req1 holding the grant. Next cycle: `fifo_level`=0, `grant_vld`=0, no further `tx_wr`, and req1 is re-granted on its next valid.
- **Reset mid-operation.** Pulse `resetq` low during DRAIN. All outputs go to 0 asynchronously, and normal operation resumes after release.
